// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - framed streaming CRC engine with result hold and error pulses
module crc_stream_engine #(
  parameter int          p_len     = 32,
  parameter int          p_width   = 8,
  parameter logic [31:0] p_polynom = 32'h04C11DB7,
  parameter logic [31:0] p_init    = 32'hFFFFFFFF,
  parameter logic [31:0] p_xorout  = 32'hFFFFFFFF,
  parameter int          p_refin   = 1,
  parameter int          p_refout  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [p_width-1:0] in_data,
  input  logic               in_sof,
  input  logic               in_eof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [p_len-1:0]   out_crc,
  output logic [15:0]        out_len,
  output logic               err_abort,
  output logic               err_orphan
);

  localparam int               c_bytes = p_width / 8;
  localparam logic [p_len-1:0] c_poly  = p_polynom[p_len-1:0];
  localparam logic [p_len-1:0] c_init  = p_init[p_len-1:0];
  localparam logic [p_len-1:0] c_xor   = p_xorout[p_len-1:0];
  localparam logic [16:0]      c_step  = 17'(c_bytes);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLD} state_t;

  state_t           state;
  logic [p_len-1:0] crc;
  logic [15:0]      len;

  logic             accept;
  logic             restart;
  logic [p_len-1:0] crc_start;
  logic [p_len-1:0] crc_cont;
  logic [p_len-1:0] beat_crc;
  logic [16:0]      len_sum;
  logic [15:0]      beat_len;

  // Bit-serial CRC unrolled over every byte of the beat; byte 0 first,
  // bits LSB first when input reflection is enabled, MSB first otherwise.
  function automatic logic [p_len-1:0] crc_update(input logic [p_len-1:0] c,
                                                  input logic [p_width-1:0] d);
    logic [p_len-1:0] r;
    logic             b;
    r = c;
    for (int i = 0; i < c_bytes; i++) begin
      for (int j = 0; j < 8; j++) begin
        b = (p_refin != 0) ? d[8*i + j] : d[8*i + 7 - j];
        if (r[p_len-1] ^ b) r = {r[p_len-2:0], 1'b0} ^ c_poly;
        else                r = {r[p_len-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  function automatic logic [p_len-1:0] reflect(input logic [p_len-1:0] c);
    logic [p_len-1:0] r;
    for (int i = 0; i < p_len; i++) r[i] = c[p_len-1-i];
    return r;
  endfunction

  function automatic logic [p_len-1:0] finalize(input logic [p_len-1:0] c);
    return ((p_refout != 0) ? reflect(c) : c) ^ c_xor;
  endfunction

  // A beat starts a fresh frame in IDLE or whenever sof is set (abort restart).
  always_comb begin
    accept    = in_valid && in_ready;
    restart   = (state == IDLE) || in_sof;
    crc_start = crc_update(c_init, in_data);
    crc_cont  = crc_update(crc, in_data);
    beat_crc  = restart ? crc_start : crc_cont;
    len_sum   = {1'b0, len} + c_step;
    beat_len  = restart ? c_step[15:0] : (len_sum[16] ? 16'hFFFF : len_sum[15:0]);
  end

  // Frame FSM with registered handshake, result and error pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      crc        <= c_init;
      len        <= 16'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_crc    <= '0;
      out_len    <= 16'd0;
      err_abort  <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      err_abort  <= 1'b0;
      err_orphan <= 1'b0;
      case (state)
        IDLE, ACTIVE: begin
          if (accept) begin
            if (state == IDLE && !in_sof) begin
              err_orphan <= 1'b1;
            end else begin
              err_abort <= (state == ACTIVE) && in_sof;
              crc       <= beat_crc;
              len       <= beat_len;
              if (in_eof) begin
                state     <= HOLD;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
                out_crc   <= finalize(beat_crc);
                out_len   <= beat_len;
              end else begin
                state <= ACTIVE;
              end
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_crc   <= '0;
            out_len   <= 16'd0;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - randomized self-checking bench for crc_stream_engine
module tb_crc_stream_engine;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_data = 8'h00;

  logic        a_in_ready, a_out_valid, a_err_abort, a_err_orphan;
  logic [31:0] a_out_crc;
  logic [15:0] a_out_len;
  logic        c_in_ready, c_out_valid, c_err_abort, c_err_orphan;
  logic [7:0]  c_out_crc;
  logic [15:0] c_out_len;
  logic        d_in_ready, d_out_valid, d_err_abort, d_err_orphan;
  logic [15:0] d_out_crc;
  logic [15:0] d_out_len;

  logic        b_in_valid = 1'b0, b_sof = 1'b0, b_eof = 1'b0, b_out_ready = 1'b1;
  logic [23:0] b_in_data = 24'h0;
  logic        b_in_ready, b_out_valid, b_err_abort, b_err_orphan;
  logic [31:0] b_out_crc;
  logic [15:0] b_out_len;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  crc_stream_engine u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_crc(a_out_crc), .out_len(a_out_len), .err_abort(a_err_abort), .err_orphan(a_err_orphan));

  crc_stream_engine #(.p_len(8), .p_width(8), .p_polynom(32'h31), .p_init(32'h0),
                      .p_xorout(32'h0), .p_refin(1), .p_refout(1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_crc(c_out_crc), .out_len(c_out_len), .err_abort(c_err_abort), .err_orphan(c_err_orphan));

  crc_stream_engine #(.p_len(16), .p_width(8), .p_polynom(32'h1021), .p_init(32'hFFFF),
                      .p_xorout(32'h0), .p_refin(0), .p_refout(0)) u_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d_in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .out_valid(d_out_valid), .out_ready(out_ready),
    .out_crc(d_out_crc), .out_len(d_out_len), .err_abort(d_err_abort), .err_orphan(d_err_orphan));

  crc_stream_engine #(.p_width(24)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sof(b_sof), .in_eof(b_eof), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_crc(b_out_crc), .out_len(b_out_len), .err_abort(b_err_abort), .err_orphan(b_err_orphan));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev_n(input logic [31:0] x, input int n);
    logic [31:0] r = 32'h0;
    for (int i = 0; i < n; i++) r[i] = x[n-1-i];
    return r;
  endfunction

  // Reference CRC over a whole byte list: reflected (shift-right) form for
  // refin, textbook MSB-first form otherwise.
  function automatic logic [31:0] ref_crc(input bq_t q, input int len, input logic [31:0] poly,
                                          input logic [31:0] init, input logic [31:0] xo,
                                          input bit refin, input bit refout);
    logic [31:0] mask, c, res, rp, top;
    logic [7:0]  b;
    logic        fb;
    mask = (len == 32) ? 32'hFFFFFFFF : ((32'h1 << len) - 1);
    if (refin) begin
      rp = rev_n(poly & mask, len);
      c  = rev_n(init & mask, len);
      foreach (q[i]) begin
        c = c ^ {24'h0, q[i]};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ rp) : (c >> 1);
      end
      res = refout ? c : rev_n(c, len);
    end else begin
      top = 32'h1 << (len - 1);
      c   = init & mask;
      foreach (q[i]) begin
        b = q[i];
        for (int j = 7; j >= 0; j--) begin
          fb = ((c & top) != 0) ^ b[j];
          c  = (c << 1) & mask;
          if (fb) c = c ^ (poly & mask);
        end
      end
      res = refout ? rev_n(c, len) : c;
    end
    return (res ^ xo) & mask;
  endfunction

  // Transaction-level expectation for the three byte-wide instances.
  int          ms = 0;
  bq_t         frame;
  bit          e_valid = 0, e_ready = 1, e_abort = 0, e_orphan = 0;
  logic [31:0] e_len = 0, e_crc_a = 0, e_crc_c = 0, e_crc_d = 0;

  task automatic enter_hold();
    ms      = 2;
    e_valid = 1;
    e_ready = 0;
    e_len   = (frame.size() > 65535) ? 32'hFFFF : 32'(frame.size());
    e_crc_a = ref_crc(frame, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
    e_crc_c = ref_crc(frame, 8, 32'h31, 32'h0, 32'h0, 1, 1);
    e_crc_d = ref_crc(frame, 16, 32'h1021, 32'hFFFF, 32'h0, 0, 0);
  endtask

  initial forever begin
    @(posedge clk);
    e_abort  = 0;
    e_orphan = 0;
    if (rst) begin
      ms = 0; e_valid = 0; e_ready = 1; frame.delete();
    end else if (ms == 2) begin
      if (out_ready) begin ms = 0; e_valid = 0; e_ready = 1; end
    end else if (in_valid) begin
      if (in_sof) begin
        if (ms == 1) e_abort = 1;
        frame.delete();
        frame.push_back(in_data);
        if (in_eof) enter_hold(); else ms = 1;
      end else if (ms == 1) begin
        frame.push_back(in_data);
        if (in_eof) enter_hold();
      end else begin
        e_orphan = 1;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", {31'h0, a_in_ready}, {31'h0, e_ready});
      chk("out_valid", {31'h0, a_out_valid}, {31'h0, e_valid});
      chk("out_len", {16'h0, a_out_len}, e_valid ? e_len : 32'h0);
      chk("crc32", a_out_crc, e_valid ? e_crc_a : 32'h0);
      chk("crc8", {24'h0, c_out_crc}, e_valid ? e_crc_c : 32'h0);
      chk("crc16", {16'h0, d_out_crc}, e_valid ? e_crc_d : 32'h0);
      chk("err_abort", {31'h0, a_err_abort}, {31'h0, e_abort});
      chk("err_orphan", {31'h0, a_err_orphan}, {31'h0, e_orphan});
    end
  end

  task automatic send_beat(input logic [7:0] d, input bit s, input bit e);
    int k = 0;
    in_data = d; in_sof = s; in_eof = e; in_valid = 1;
    do begin @(negedge clk); k++; end while (!a_in_ready && k < 50);
    if (!a_in_ready) chk("beat_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    in_valid = 0; in_sof = 0; in_eof = 0;
  endtask

  task automatic send_q(input bq_t q);
    foreach (q[i]) send_beat(q[i], i == 0, i == q.size() - 1);
  endtask

  task automatic send_beat_b(input logic [23:0] d, input bit s, input bit e);
    int k = 0;
    b_in_data = d; b_sof = s; b_eof = e; b_in_valid = 1;
    do begin @(negedge clk); k++; end while (!b_in_ready && k < 50);
    if (!b_in_ready) chk("beat_b_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    b_in_valid = 0; b_sof = 0; b_eof = 0;
  endtask

  task automatic settle();
    @(posedge clk); #1;
  endtask

  bq_t s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  initial begin
    bq_t bq;
    int  nb;
    logic [23:0] w;

    chk("model_crc32", ref_crc(s9, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1), 32'hCBF43926);
    chk("model_crc8", ref_crc(s9, 8, 32'h31, 32'h0, 32'h0, 1, 1), 32'hA1);
    chk("model_crc16", ref_crc(s9, 16, 32'h1021, 32'hFFFF, 32'h0, 0, 0), 32'h29B1);

    rst = 1;
    @(posedge clk); #1;
    chk_en = 1;
    settle();
    rst = 0;
    @(negedge clk);
    chk("rst_in_ready", {31'h0, a_in_ready}, 32'h1);
    chk("rst_out_crc", a_out_crc, 32'h0);
    settle();

    send_q(s9);
    @(negedge clk);
    chk("vec_crc32", a_out_crc, 32'hCBF43926);
    chk("vec_crc8", {24'h0, c_out_crc}, 32'hA1);
    chk("vec_crc16", {16'h0, d_out_crc}, 32'h29B1);
    chk("vec_len", {16'h0, a_out_len}, 32'd9);
    settle();

    out_ready = 0;
    send_q(s9);
    in_data = 8'h5A; in_sof = 1; in_eof = 1; in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'h0, a_out_valid}, 32'h1);
      chk("hold_crc", a_out_crc, 32'hCBF43926);
      chk("hold_ready", {31'h0, a_in_ready}, 32'h0);
    end
    settle();
    out_ready = 1;
    settle();
    @(negedge clk);
    chk("release_ready", {31'h0, a_in_ready}, 32'h1);
    chk("release_valid", {31'h0, a_out_valid}, 32'h0);
    settle();
    in_valid = 0; in_sof = 0; in_eof = 0;
    @(negedge clk);
    chk("single_len", {16'h0, a_out_len}, 32'd1);
    settle();

    send_beat(8'h77, 0, 0);
    @(negedge clk);
    chk("orphan_pulse", {31'h0, a_err_orphan}, 32'h1);
    @(negedge clk);
    chk("orphan_clear", {31'h0, a_err_orphan}, 32'h0);
    chk("orphan_noresult", {31'h0, a_out_valid}, 32'h0);
    settle();

    send_beat(8'hAA, 1, 0);
    send_beat(8'hBB, 0, 0);
    send_beat(8'hCC, 0, 0);
    send_beat(8'hDD, 0, 0);
    send_beat(8'h31, 1, 0);
    @(negedge clk);
    chk("abort_pulse", {31'h0, a_err_abort}, 32'h1);
    settle();
    for (int i = 1; i < 9; i++) send_beat(s9[i], 0, i == 8);
    @(negedge clk);
    chk("abort_crc", a_out_crc, 32'hCBF43926);
    chk("abort_len", {16'h0, a_out_len}, 32'd9);
    settle();

    for (int i = 0; i < 5; i++) send_beat(s9[i], i == 0, 0);
    rst = 1; settle(); rst = 0;
    @(negedge clk);
    chk("rst_act_valid", {31'h0, a_out_valid}, 32'h0);
    chk("rst_act_ready", {31'h0, a_in_ready}, 32'h1);
    settle();
    out_ready = 0;
    send_q(s9);
    rst = 1; settle(); rst = 0;
    @(negedge clk);
    chk("rst_hold_valid", {31'h0, a_out_valid}, 32'h0);
    settle();
    out_ready = 1;
    send_q(s9);
    @(negedge clk);
    chk("after_rst_crc", a_out_crc, 32'hCBF43926);
    settle();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_sof    = ($urandom_range(0, 99) < 25);
      in_eof    = ($urandom_range(0, 99) < 25);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 99) < 60);
      rst       = ($urandom_range(0, 99) < 1);
      settle();
    end
    rst = 0; in_valid = 0; in_sof = 0; in_eof = 0; out_ready = 1;
    repeat (3) settle();

    send_beat_b(24'h333231, 1, 0);
    send_beat_b(24'h363534, 0, 0);
    send_beat_b(24'h393837, 0, 1);
    @(negedge clk);
    chk("w24_valid", {31'h0, b_out_valid}, 32'h1);
    chk("w24_crc", b_out_crc, 32'hCBF43926);
    chk("w24_len", {16'h0, b_out_len}, 32'd9);
    settle();

    for (int f = 0; f < 20; f++) begin
      nb = $urandom_range(1, 5);
      bq.delete();
      for (int i = 0; i < nb; i++) begin
        w = 24'($urandom);
        bq.push_back(w[7:0]); bq.push_back(w[15:8]); bq.push_back(w[23:16]);
        send_beat_b(w, i == 0, i == nb - 1);
      end
      @(negedge clk);
      chk("w24_rand_crc", b_out_crc,
          ref_crc(bq, 32, 32'h04C11DB7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1));
      chk("w24_rand_len", {16'h0, b_out_len}, 32'(3 * nb));
      chk("w24_no_err", {30'h0, b_err_abort, b_err_orphan}, 32'h0);
      settle();
    end

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/crc_stream_engine.md
CRC_STREAM_ENGINE -- requirements
Module: crc_stream_engine

Interface
REQ-001 SHALL have parameter p_len, default 32, CRC register width in bits (legal 8..32).
REQ-002 SHALL have parameter p_width, default 8, data bits per beat (multiple of 8, legal 8..64).
REQ-003 SHALL have parameter p_polynom, default 32'h04C11DB7, generator polynomial, low p_len bits used.
REQ-004 SHALL have parameter p_init, default 32'hFFFFFFFF, CRC preset, low p_len bits used.
REQ-005 SHALL have parameter p_xorout, default 32'hFFFFFFFF, final XOR, low p_len bits used.
REQ-006 SHALL have parameter p_refin, default 1, 1 = each input byte processed LSB first.
REQ-007 SHALL have parameter p_refout, default 1, 1 = result bit-reversed over p_len before final XOR.
REQ-008 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-009 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-010 SHALL have ports in_valid input 1, in_ready output 1: input beat handshake.
REQ-011 SHALL have port in_data  input  p_width  beat data; byte 0 = in_data[7:0], processed first.
REQ-012 SHALL have ports in_sof input 1, in_eof input 1: first/last beat of frame, qualified by in_valid.
REQ-013 SHALL have ports out_valid output 1, out_ready input 1: result handshake.
REQ-014 SHALL have port out_crc  output  p_len  final CRC of frame.
REQ-015 SHALL have port out_len  output  16  frame length in bytes, saturating at 16'hFFFF.
REQ-016 SHALL have ports err_abort output 1, err_orphan output 1: single-cycle error pulses.

Function
REQ-017 SHALL implement FSM states IDLE, ACTIVE, HOLD; beat accepted when in_valid && in_ready.
REQ-018 SHALL drive in_ready = 1 in IDLE and ACTIVE, 0 in HOLD.
REQ-019 SHALL in IDLE on accepted beat with in_sof: load CRC = update(p_init, in_data), len = p_width/8; go ACTIVE, or HOLD if in_eof.
REQ-020 SHALL in ACTIVE on accepted beat without in_sof: CRC = update(CRC, in_data), len += p_width/8 saturating; go HOLD if in_eof.
REQ-021 SHALL process all p_width/8 bytes of a beat in one cycle (combinational unrolled update, serial-equivalent bit order).
REQ-022 SHALL in HOLD drive out_valid = 1, out_crc = (p_refout ? reverse(CRC) : CRC) ^ p_xorout, out_len = len, all stable until out_valid && out_ready.
REQ-023 SHALL return HOLD -> IDLE on out_ready; result first visible the cycle after the eof beat is accepted (latency 1).
REQ-024 SHALL treat accepted in_sof in ACTIVE as abort: discard partial frame, pulse err_abort next cycle, restart frame with this beat per REQ-019.
REQ-025 SHALL drop an accepted beat without in_sof in IDLE, pulse err_orphan next cycle, stay IDLE.
REQ-026 SHALL accept single-beat frame (in_sof && in_eof) in IDLE, entering HOLD directly.
REQ-027 SHALL keep out_crc, out_len at 0 when out_valid = 0.

Reset
REQ-028 SHALL on rst = 1 force IDLE, CRC = p_init, len = 0, out_valid = 0, out_crc = 0, out_len = 0, err_abort = 0, err_orphan = 0, next cycle; in_ready = 1 after reset.
REQ-029 SHALL abandon any frame or pending result when rst asserts in ACTIVE or HOLD; no result emitted.

Verification
REQ-030 Defaults, p_width=8, bytes "123456789" (0x31..0x39), sof on first, eof on last, out_ready=1 -> out_valid 1 cycle after last beat, out_crc=32'hCBF43926, out_len=9.
REQ-031 Defaults, p_width=24, same 9 bytes in 3 beats (24'h333231, 24'h363534, 24'h393837) -> out_crc=32'hCBF43926, out_len=9.
REQ-032 p_len=8, p_polynom=8'h31, p_init=0, p_xorout=0, refin/refout=1, "123456789" -> out_crc=8'hA1; p_len=16, p_polynom=16'h1021, p_init=16'hFFFF, p_xorout=0, refin/refout=0 -> out_crc=16'h29B1.
REQ-033 out_ready held 0 for 5 cycles after result -> out_valid, out_crc stable, in_ready=0 throughout; new sof beat presented meanwhile not accepted until cycle after out_ready=1.
REQ-034 Beat without sof in IDLE -> err_orphan pulse 1 cycle, no result; sof mid-frame after 4 bytes then "123456789" -> err_abort pulse, out_crc=32'hCBF43926, out_len=9.
REQ-035 rst asserted in ACTIVE after 5 bytes and in HOLD before out_ready -> out_valid=0 next cycle, in_ready=1, subsequent "123456789" frame gives 32'hCBF43926.
